// File: rtl/lab4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab4_pkg
// Description : Shared types and default sizes for the LAB4 serial loader.
// Revision    : 1.0 - initial release
// ============================================================================
package lab4_pkg;

    // Default number of LAB4 chips on the board
    localparam int LAB4_NCHIPS     = 12;
    // Default serial word length per load
    localparam int LAB4_NBITS      = 24;
    // Default width of the half-period prescale value
    localparam int LAB4_PRESCALE_W = 8;

    // Loader sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4
    } lab4_state_e;

endpackage
`default_nettype wire

// File: rtl/lab4_prescale_counter.sv
`default_nettype none
// ============================================================================
// Module      : lab4_prescale_counter
// Description : Phase timer. Loads P, counts down while enabled and flags
//               the terminal count, so each enabled phase lasts P+1 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module lab4_prescale_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;

    // Down-counter: a load always wins, otherwise count towards zero and hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    // Terminal count marks the last cycle of the current phase
    assign tc = en && (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/lab4_serial_loader.sv
`default_nettype none
// ============================================================================
// Module      : lab4_serial_loader
// Description : Serial configuration loader for LAB4 chips. Shifts one
//               NBITS word into one chip (or all chips in broadcast) using
//               per-chip SIN/SCLK lines, then pulses PCLK to latch it.
//               All chip-side outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module lab4_serial_loader
    import lab4_pkg::*;
#(
    parameter int NCHIPS     = LAB4_NCHIPS,
    parameter int NBITS      = LAB4_NBITS,
    parameter int PRESCALE_W = LAB4_PRESCALE_W,
    parameter int LSB_FIRST  = 0,
    localparam int SEL_W     = (NCHIPS > 1) ? $clog2(NCHIPS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  go_i,
    input  logic [NBITS-1:0]      dat_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  bcast_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [NCHIPS-1:0]     sin_o,
    output logic [NCHIPS-1:0]     sclk_o,
    output logic [NCHIPS-1:0]     pclk_o
);

    localparam int               CNT_W      = $clog2(NBITS + 1);
    localparam logic [SEL_W:0]   NCHIPS_V   = (SEL_W + 1)'(NCHIPS);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NBITS - 1);

    lab4_state_e           state;
    logic [1:0]            rst_sync;
    logic                  run_ok;
    logic [NBITS-1:0]      dat_q;
    logic [NCHIPS-1:0]     tgt_q;
    logic [PRESCALE_W-1:0] p_q;
    logic [CNT_W-1:0]      bit_cnt;

    logic                  sel_bad;
    logic                  accept;
    logic                  reject;
    logic [NCHIPS-1:0]     req_mask;
    logic                  first_bit;
    logic [CNT_W-1:0]      next_cnt;
    logic [CNT_W-1:0]      next_idx;
    logic                  next_bit;
    logic                  last_bit;
    logic                  phase_active;
    logic                  load;
    logic [PRESCALE_W-1:0] load_val;
    logic                  tc;

    // Reset release is re-timed so a request is honoured only once the
    // release has propagated through two flops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run_ok = rst_sync[1];

    // Request qualification; only evaluated from IDLE
    assign sel_bad = !bcast_i && ({1'b0, sel_i} >= NCHIPS_V);
    assign accept  = (state == ST_IDLE) && go_i && run_ok && !sel_bad;
    assign reject  = (state == ST_IDLE) && go_i && run_ok && sel_bad;

    // Target mask for the incoming request: every chip or just the selected one
    generate
        for (genvar c = 0; c < NCHIPS; c++) begin : g_mask
            assign req_mask[c] = bcast_i || (sel_i == SEL_W'(c));
        end
    endgenerate

    // First bit on the wire comes straight from the request word
    assign first_bit = (LSB_FIRST != 0) ? dat_i[0] : dat_i[NBITS-1];

    // Bit position of the next bit to present, from the count of bits done
    assign next_cnt = bit_cnt + CNT_W'(1);
    assign next_idx = (LSB_FIRST != 0) ? next_cnt : (LAST_CNT - next_cnt);
    assign last_bit = (bit_cnt == LAST_CNT);

    // Pick the next data bit without a variable-width index
    always_comb begin
        next_bit = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            if (next_idx == CNT_W'(i)) begin
                next_bit = dat_q[i];
            end
        end
    end

    // Phase timer control: reload P on acceptance and at every phase change
    assign phase_active = (state == ST_SETUP) || (state == ST_HIGH) ||
                          (state == ST_LATCH);
    assign load         = accept || (phase_active && tc);
    assign load_val     = (state == ST_IDLE) ? prescale_i : p_q;

    lab4_prescale_counter #(
        .WIDTH    (PRESCALE_W)
    ) u_timer (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .load     (load),
        .load_val (load_val),
        .en       (phase_active),
        .tc       (tc)
    );

    // Sequencer with registered chip-side and status outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            dat_q   <= '0;
            tgt_q   <= '0;
            p_q     <= '0;
            bit_cnt <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            sin_o   <= '0;
            sclk_o  <= '0;
            pclk_o  <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sin_o  <= '0;
                    sclk_o <= '0;
                    pclk_o <= '0;
                    busy_o <= 1'b0;
                    if (reject) begin
                        err_o <= 1'b1;
                    end else if (accept) begin
                        dat_q   <= dat_i;
                        tgt_q   <= req_mask;
                        p_q     <= prescale_i;
                        bit_cnt <= '0;
                        busy_o  <= 1'b1;
                        sin_o   <= req_mask & {NCHIPS{first_bit}};
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tc) begin
                        sclk_o <= tgt_q;
                        state  <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tc) begin
                        sclk_o  <= '0;
                        bit_cnt <= next_cnt;
                        if (last_bit) begin
                            sin_o  <= '0;
                            pclk_o <= tgt_q;
                            state  <= ST_LATCH;
                        end else begin
                            sin_o  <= tgt_q & {NCHIPS{next_bit}};
                            state  <= ST_SETUP;
                        end
                    end
                end
                ST_LATCH: begin
                    if (tc) begin
                        pclk_o <= '0;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_o  <= 1'b0;
                    bit_cnt <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    sin_o  <= '0;
                    sclk_o <= '0;
                    pclk_o <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lab4_serial_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab4_serial_loader
// Description : Directed self-checking bench for lab4_serial_loader
//               (default build plus a 16-bit LSB-first build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lab4_serial_loader;

    logic        clk;
    logic        rst_n;
    logic        go, go_b;
    logic [23:0] dat;
    logic [15:0] dat_b;
    logic [3:0]  sel;
    logic        bcast;
    logic [7:0]  prescale;

    logic        busy_a, done_a, err_a;
    logic [11:0] sin_a, sclk_a, pclk_a;
    logic        busy_b, done_b, err_b;
    logic [11:0] sin_b, sclk_b, pclk_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Watcher results
    int          w_busy, w_rise, w_span, w_pcyc, w_ppul, w_done, w_bad, w_shi;
    logic [23:0] w_shift;

    lab4_serial_loader u_dut_a (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .go_i       (go),
        .dat_i      (dat),
        .sel_i      (sel),
        .bcast_i    (bcast),
        .prescale_i (prescale),
        .busy_o     (busy_a),
        .done_o     (done_a),
        .err_o      (err_a),
        .sin_o      (sin_a),
        .sclk_o     (sclk_a),
        .pclk_o     (pclk_a)
    );

    lab4_serial_loader #(
        .NBITS      (16),
        .LSB_FIRST  (1)
    ) u_dut_b (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .go_i       (go_b),
        .dat_i      (dat_b),
        .sel_i      (sel),
        .bcast_i    (bcast),
        .prescale_i (prescale),
        .busy_o     (busy_b),
        .done_o     (done_b),
        .err_o      (err_b),
        .sin_o      (sin_b),
        .sclk_o     (sclk_b),
        .pclk_o     (pclk_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request on the given instance and leave at the next negedge
    task automatic start(input bit use_b, input logic [23:0] d, input logic [3:0] s,
                         input logic b, input logic [7:0] ps);
        @(negedge clk);
        dat      = d;
        dat_b    = d[15:0];
        sel      = s;
        bcast    = b;
        prescale = ps;
        if (use_b) go_b = 1'b1;
        else       go   = 1'b1;
        @(negedge clk);
        go   = 1'b0;
        go_b = 1'b0;
    endtask

    // Observe a transfer at negedges while busy is high, collecting the
    // bit stream seen at SCLK rising samples and the PCLK/done activity.
    task automatic watch(input bit use_b, input logic [11:0] tmask,
                         input int go_at, input int abort_at);
        logic [11:0] s, k, p;
        logic        bz, dn, prev_k, prev_p;
        int          first_rise, last_rise;
        w_busy = 0; w_rise = 0; w_span = 0; w_pcyc = 0; w_ppul = 0;
        w_done = 0; w_bad = 0; w_shi = 0; w_shift = '0;
        prev_k = 1'b0; prev_p = 1'b0; first_rise = -1; last_rise = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s  = use_b ? sin_b  : sin_a;
            k  = use_b ? sclk_b : sclk_a;
            p  = use_b ? pclk_b : pclk_a;
            bz = use_b ? busy_b : busy_a;
            dn = use_b ? done_b : done_a;
            if (!bz) break;
            w_busy++;
            if (((s | k | p) & ~tmask) != 12'h000) w_bad++;
            if ((s & tmask) != 12'h000 && (s & tmask) != tmask) w_bad++;
            if ((k & tmask) != 12'h000 && (k & tmask) != tmask) w_bad++;
            if ((p & tmask) != 12'h000 && (p & tmask) != tmask) w_bad++;
            if ((s & tmask) != 12'h000) w_shi++;
            if ((k & tmask) != 12'h000 && !prev_k) begin
                w_shift = {w_shift[22:0], ((s & tmask) != 12'h000)};
                w_rise++;
                if (first_rise < 0) first_rise = cyc;
                last_rise = cyc;
            end
            if ((p & tmask) != 12'h000) begin
                w_pcyc++;
                if (!prev_p) w_ppul++;
            end
            if (dn) w_done++;
            prev_k = ((k & tmask) != 12'h000);
            prev_p = ((p & tmask) != 12'h000);
            if (go_at > 0 && cyc == go_at) begin
                go  = 1'b1;
                dat = 24'hFFFFFF;
                sel = 4'd1;
            end else begin
                go = 1'b0;
            end
            if (abort_at > 0 && w_rise == abort_at) begin
                rst_n = 1'b0;
                #1;
                if (busy_a || done_a || err_a || (|sin_a) || (|sclk_a) || (|pclk_a) ||
                    busy_b || (|sin_b) || (|sclk_b) || (|pclk_b)) w_bad++;
                break;
            end
            @(negedge clk);
        end
        w_span = (first_rise < 0) ? -1 : (last_rise - first_rise);
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; go_b = 1'b0; dat = '0; dat_b = '0;
        sel = '0; bcast = 1'b0; prescale = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_err",  {31'd0, err_a},  32'd0);
        chk("rst_pins", {20'd0, sin_a | sclk_a | pclk_a}, 32'd0);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // P=10 single chip 0, MSB first
        start(1'b0, 24'h123456, 4'd0, 1'b0, 8'd10);
        watch(1'b0, 12'h001, 0, 0);
        chk("t1_busy",   w_busy, 32'd540);
        chk("t1_data",   {8'd0, w_shift}, 32'h123456);
        chk("t1_rises",  w_rise, 32'd24);
        chk("t1_span",   w_span, 32'd506);
        chk("t1_pclk_w", w_pcyc, 32'd11);
        chk("t1_pclk_n", w_ppul, 32'd1);
        chk("t1_done",   w_done, 32'd1);
        chk("t1_stray",  w_bad,  32'd0);
        chk("t1_done_lo", {31'd0, done_a}, 32'd0);

        // P=0 broadcast to all chips
        start(1'b0, 24'hA5A5A5, 4'd0, 1'b1, 8'd0);
        watch(1'b0, 12'hFFF, 0, 0);
        chk("t2_busy",   w_busy, 32'd50);
        chk("t2_data",   {8'd0, w_shift}, 32'hA5A5A5);
        chk("t2_rises",  w_rise, 32'd24);
        chk("t2_period", w_span, 32'd46);
        chk("t2_pclk_w", w_pcyc, 32'd1);
        chk("t2_pclk_n", w_ppul, 32'd1);
        chk("t2_uniform", w_bad, 32'd0);

        // Out-of-range select is rejected
        @(negedge clk);
        sel = 4'd12; bcast = 1'b0; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("err_pulse", {31'd0, err_a},  32'd1);
        chk("err_busy",  {31'd0, busy_a}, 32'd0);
        chk("err_pins",  {20'd0, sin_a | sclk_a | pclk_a}, 32'd0);
        @(negedge clk);
        chk("err_one",   {31'd0, err_a},  32'd0);
        chk("err_idle",  {31'd0, busy_a}, 32'd0);

        // Request during a transfer is ignored (P=3, chip 5)
        start(1'b0, 24'h5A3C96, 4'd5, 1'b0, 8'd3);
        watch(1'b0, 12'h020, 100, 0);
        chk("t3_busy",  w_busy, 32'd197);
        chk("t3_data",  {8'd0, w_shift}, 32'h5A3C96);
        chk("t3_done",  w_done, 32'd1);
        chk("t3_stray", w_bad,  32'd0);
        @(negedge clk);
        chk("t3_no_requeue", {31'd0, busy_a}, 32'd0);

        // Reset mid-transfer (P=2, chip 7) aborts without a latch pulse
        start(1'b0, 24'h3C3C3C, 4'd7, 1'b0, 8'd2);
        watch(1'b0, 12'h080, 0, 10);
        chk("t4_rises",   w_rise, 32'd10);
        chk("t4_no_pclk", w_ppul, 32'd0);
        chk("t4_zeroed",  w_bad,  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dat = 24'h00F00F; sel = 4'd3; bcast = 1'b0; prescale = 8'd2; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("t4_sync_go", {31'd0, busy_a}, 32'd0);
        repeat (2) @(negedge clk);
        start(1'b0, 24'h00F00F, 4'd3, 1'b0, 8'd2);
        watch(1'b0, 12'h008, 0, 0);
        chk("t4_busy", w_busy, 32'd148);
        chk("t4_data", {8'd0, w_shift}, 32'h00F00F);
        chk("t4_done", w_done, 32'd1);
        chk("t4_stray", w_bad, 32'd0);

        // 16-bit LSB-first build: only the first bit is high
        start(1'b1, 24'h000001, 4'd2, 1'b0, 8'd1);
        watch(1'b1, 12'h004, 0, 0);
        chk("t5_busy",  w_busy, 32'd67);
        chk("t5_data",  {8'd0, w_shift}, 32'h008000);
        chk("t5_rises", w_rise, 32'd16);
        chk("t5_sin_hi", w_shi, 32'd4);
        chk("t5_pclk_n", w_ppul, 32'd1);
        chk("t5_stray", w_bad,  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lab4_serial_loader.md
LAB4_SERIAL_LOADER -- requirements
Module: lab4_serial_loader

Interface
REQ-001 Parameter NCHIPS, 12, number of LAB4 chips driven.
REQ-002 Parameter NBITS, 24, serial word length per load.
REQ-003 Parameter PRESCALE_W, 8, width of prescale input.
REQ-004 Parameter LSB_FIRST, 0, 0 = shift MSB first, 1 = LSB first.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk_i  in  1  system clock.
REQ-007 rst_n_i  in  1  async active-low reset.
REQ-008 go_i  in  1  start request, sampled on rising clk_i.
REQ-009 dat_i  in  NBITS  word to load.
REQ-010 sel_i  in  clog2(NCHIPS)  target chip index.
REQ-011 bcast_i  in  1  1 = load all chips simultaneously.
REQ-012 prescale_i  in  PRESCALE_W  half-period length minus one.
REQ-013 busy_o  out  1  transfer in progress.
REQ-014 done_o  out  1  one-cycle pulse at transfer end.
REQ-015 err_o  out  1  one-cycle pulse on rejected request.
REQ-016 SIN, SCLK, PCLK  out  NCHIPS each  per-chip serial data, shift clock, latch clock.

Function
REQ-017 States SHALL be IDLE, SETUP, HIGH, LATCH, DONE.
REQ-018 In IDLE, go_i=1 SHALL latch dat_i, sel_i, bcast_i, prescale_i (P) and enter SETUP next cycle; busy_o rises that same edge.
REQ-019 go_i with bcast_i=0 and sel_i>=NCHIPS SHALL be rejected: err_o pulses one cycle, state stays IDLE, busy_o stays 0.
REQ-020 go_i while busy_o=1 SHALL be ignored; latched parameters SHALL NOT change mid-transfer.
REQ-021 SETUP: SIN of target(s) = current bit, SCLK low, for P+1 cycles, then HIGH.
REQ-022 HIGH: SCLK of target(s) high, SIN held, for P+1 cycles; then SETUP for next bit, or LATCH after bit NBITS.
REQ-023 Bit order: MSB (bit NBITS-1) first when LSB_FIRST=0, bit 0 first otherwise.
REQ-024 LATCH: SIN low, SCLK low, PCLK of target(s) high for P+1 cycles, then DONE.
REQ-025 DONE: one cycle, done_o=1, busy_o=1, then IDLE with busy_o=0.
REQ-026 Busy duration SHALL be exactly (2*NBITS+1)*(P+1)+1 cycles; P=0 is legal (one-cycle phases).
REQ-027 Target set = all chips when latched bcast=1, else only chip sel; non-target SIN/SCLK/PCLK SHALL be 0 at all times.
REQ-028 All SIN/SCLK/PCLK outputs SHALL be registered (no combinational glitches); in IDLE all are 0.
REQ-029 go_i in the DONE cycle SHALL be ignored; new transfer accepted from IDLE only.

Reset
REQ-030 rst_n_i low SHALL immediately force IDLE, all SIN/SCLK/PCLK, busy_o, done_o, err_o to 0, prescale counter and bit counter to 0.
REQ-031 Reset mid-transfer SHALL abort without PCLK pulse; release SHALL be synchronised so first go_i is honoured no earlier than second rising edge after deassertion.

Structure
REQ-032 Package lab4_pkg SHALL hold the state enum and defaults LAB4_NCHIPS=12, LAB4_NBITS=24.
REQ-033 The phase timer SHALL be sub-module lab4_prescale_counter (load P, count down, terminal-count pulse).
REQ-034 Bit counter width SHALL be clog2(NBITS+1).

Verification
REQ-035 P=10, sel=0, bcast=0, dat=0x123456 -> busy 540 cycles; SIN[0] sequence 0x123456 MSB first sampled at 24 SCLK[0] rising edges; one PCLK[0] pulse 11 cycles; other chips silent; done_o one pulse.
REQ-036 P=0, bcast=1, dat=0xA5A5A5 -> all 12 SCLK toggle identically, period 2 cycles, busy 50 cycles, all PCLK pulse together.
REQ-037 sel=12, bcast=0, go=1 -> err_o one pulse, busy_o stays 0, all outputs 0.
REQ-038 go reasserted at cycle 100 of a P=3 transfer to sel=5 -> ignored; data/sel unchanged; single done_o.
REQ-039 rst_n_i low at bit 10 of a P=2 transfer -> all outputs 0 same cycle, no PCLK, next go after release completes normally.
REQ-040 LSB_FIRST=1, NBITS=16, dat=0x0001 -> SIN high only during first bit.
